serial_pattern_tx: RTL and testbench

//   Serial bit-stream transmitter: the driving end of the single-bit "w" stream consumed
//   by the team's sequence detectors (e.g. the "111" detector). Shifts out a parallel

---
 rtl/serial_pattern_tx.sv | 117 +++++++++++
 tb/tb_serial_pattern_tx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a parallel frame out MSB-first on w, optionally
// repeated back-to-back, and counts overlapping "111" windows in the emitted stream.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int HIT_W = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             w,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [HIT_W-1:0] hit_cnt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   frame;
  logic [WIDTH-1:0]   shreg;
  logic [IDX_W-1:0]   bit_idx;
  logic [CNT_W-1:0]   rep_left;
  logic [1:0]         hist;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (bit_idx == '0 && rep_left == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // w always holds the bit currently on the line; shreg holds the bits still to come.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      frame    <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      rep_left <= '0;
      hist     <= 2'b00;
      hit_cnt  <= '0;
      w        <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          w     <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            frame    <= data;
            shreg    <= data << 1;
            w        <= data[WIDTH-1];
            valid    <= 1'b1;
            busy     <= 1'b1;
            rep_left <= repeat_n;
            bit_idx  <= IDX_W'(WIDTH - 1);
            hit_cnt  <= '0;
            hist     <= 2'b00;
          end
        end
        SHIFT: begin
          hist <= {hist[0], w};
          if (hist == 2'b11 && w && hit_cnt != '1)
            hit_cnt <= hit_cnt + 1'b1;
          if (bit_idx != '0) begin
            w       <= shreg[WIDTH-1];
            shreg   <= shreg << 1;
            bit_idx <= bit_idx - 1'b1;
          end else if (rep_left != '0) begin
            w        <= frame[WIDTH-1];
            shreg    <= frame << 1;
            bit_idx  <= IDX_W'(WIDTH - 1);
            rep_left <= rep_left - 1'b1;
          end else begin
            w     <= 1'b0;
            valid <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          w     <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          w     <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx; a second instance with HIT_W=4 shares the
// stimulus to exercise hit counter saturation.
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       arst;
  logic       start;
  logic [7:0] data;
  logic [3:0] repeat_n;
  logic       w, valid, busy, done;
  logic [7:0] hit_cnt;
  logic       w2, valid2, busy2, done2;
  logic [3:0] hit_cnt2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(8), .CNT_W(4), .HIT_W(8)) dut (
    .clk(clk), .arst(arst), .start(start), .data(data), .repeat_n(repeat_n),
    .w(w), .valid(valid), .busy(busy), .done(done), .hit_cnt(hit_cnt)
  );

  serial_pattern_tx #(.WIDTH(8), .CNT_W(4), .HIT_W(4)) dut_sat (
    .clk(clk), .arst(arst), .start(start), .data(data), .repeat_n(repeat_n),
    .w(w2), .valid(valid2), .busy(busy2), .done(done2), .hit_cnt(hit_cnt2)
  );

  // Launches one transfer and checks every cycle of it; optionally keeps start high
  // throughout, and scrambles data/repeat_n once the start has been accepted.
  task automatic run_transfer(input string name, input logic [7:0] d, input logic [3:0] rn,
                              input logic [7:0] exp_hit, input logic [3:0] exp_hit2,
                              input bit hold_start);
    int n;
    logic exp_w;
    @(negedge clk);
    data = d; repeat_n = rn; start = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    data = ~d; repeat_n = 4'd0;
    n = 8 * (int'(rn) + 1);
    for (int i = 0; i < n; i++) begin
      exp_w = d[7 - (i % 8)];
      vectors++;
      if (w !== exp_w || valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
          w2 !== exp_w || valid2 !== 1'b1) begin
        miscompares++;
        $display("FAIL %s bit %0d: w=%b valid=%b busy=%b done=%b w2=%b valid2=%b, want w=%b valid=1 busy=1 done=0",
                 name, i, w, valid, busy, done, w2, valid2, exp_w);
      end
      @(negedge clk);
    end
    vectors++;
    if (done !== 1'b1 || valid !== 1'b0 || w !== 1'b0 || busy !== 1'b1 || done2 !== 1'b1) begin
      miscompares++;
      $display("FAIL %s done_cycle: done=%b valid=%b w=%b busy=%b done2=%b, want 1 0 0 1 1",
               name, done, valid, w, busy, done2);
    end
    vectors++;
    if (hit_cnt !== exp_hit || hit_cnt2 !== exp_hit2) begin
      miscompares++;
      $display("FAIL %s hit_cnt at done: got %0d/%0d, want %0d/%0d",
               name, hit_cnt, hit_cnt2, exp_hit, exp_hit2);
    end
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0 || w !== 1'b0 || hit_cnt !== exp_hit) begin
      miscompares++;
      $display("FAIL %s idle_after: done=%b busy=%b valid=%b w=%b hit=%0d, want 0 0 0 0 hit=%0d",
               name, done, busy, valid, w, hit_cnt, exp_hit);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0 || hit_cnt !== exp_hit) begin
      miscompares++;
      $display("FAIL %s stays_idle: busy=%b valid=%b done=%b hit=%0d, want 0 0 0 hit=%0d",
               name, busy, valid, done, hit_cnt, exp_hit);
    end
  endtask

  task automatic test_reset();
    arst = 1'b1; start = 1'b0; data = 8'h00; repeat_n = 4'd0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (w !== 1'b0 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || hit_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_state: w=%b valid=%b busy=%b done=%b hit=%0d, want all 0",
               w, valid, busy, done, hit_cnt);
    end
    arst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_start: busy=%b valid=%b, want 0 0", busy, valid);
    end
  endtask

  task automatic test_single_frame();
    run_transfer("e0_single", 8'hE0, 4'd0, 8'd1, 4'd1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_transfer("ff_repeat1", 8'hFF, 4'd1, 8'd14, 4'd14, 1'b0);
  endtask

  task automatic test_patterns();
    run_transfer("07_repeat1", 8'h07, 4'd1, 8'd2, 4'd2, 1'b0);
    run_transfer("b6_repeat2", 8'hB6, 4'd2, 8'd0, 4'd0, 1'b0);
  endtask

  task automatic test_start_held();
    run_transfer("e0_held", 8'hE0, 4'd0, 8'd1, 4'd1, 1'b1);
    run_transfer("e0_after_held", 8'hE0, 4'd0, 8'd1, 4'd1, 1'b0);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    data = 8'hFF; repeat_n = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (valid !== 1'b1 || w !== 1'b1 || hit_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL pre_abort_bit4: valid=%b w=%b hit=%0d, want 1 1 1", valid, w, hit_cnt);
    end
    arst = 1'b1;
    #1;
    vectors++;
    if (w !== 1'b0 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || hit_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL async_abort: w=%b valid=%b busy=%b done=%b hit=%0d, want all 0",
               w, valid, busy, done, hit_cnt);
    end
    @(negedge clk);
    arst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_quiet cycle %0d: done=%b busy=%b valid=%b, want 0 0 0",
                 i, done, busy, valid);
      end
    end
    run_transfer("e0_after_abort", 8'hE0, 4'd0, 8'd1, 4'd1, 1'b0);
  endtask

  task automatic test_saturation();
    run_transfer("ff_repeat3_sat", 8'hFF, 4'd3, 8'd30, 4'd15, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_patterns();
    test_start_held();
    test_async_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
